// File: rtl/sram_axi_arbiter_pkg.sv
// Shared constants for the SRAM-like to AXI bridge: AXI IDs, burst/size values and FSM states.
package sram_axi_arbiter_pkg;

  localparam logic [3:0] ID_INST        = 4'd0;
  localparam logic [3:0] ID_DATA        = 4'd1;
  localparam logic [3:0] ID_WRITE       = 4'd1;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_AW_W, WR_B} wr_state_t;

  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/axi_rd_arb.sv
// Grant logic for the shared AR slot; data wins by default, round-robin with ARB_RR_EN defined.
module axi_rd_arb (
`ifdef ARB_RR_EN
  input  logic clk,
  input  logic resetn,
`endif
  input  logic req_inst,
  input  logic req_data,
  output logic grant_inst,
  output logic grant_data
);

`ifdef ARB_RR_EN
  logic last_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_data <= 1'b0;
    end else if (grant_inst || grant_data) begin
      last_data <= grant_data;
    end
  end

  always_comb begin
    grant_data = req_data && (!req_inst || !last_data);
    grant_inst = req_inst && !grant_data;
  end
`else
  always_comb begin
    grant_data = req_data;
    grant_inst = req_inst && !req_data;
  end
`endif

endmodule

// File: rtl/sram_axi_arbiter.sv
// Bridges fetch/memory-stage SRAM-like ports onto one AXI master; reads of the two IDs overlap.
// ARB_RR_EN selects round-robin AR arbitration instead of fixed data priority.
module sram_axi_arbiter
  import sram_axi_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,

  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,

  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic        bvalid,
  output logic        bready
);

  rd_state_t inst_rd, inst_rd_next;
  rd_state_t data_rd, data_rd_next;
  wr_state_t wr_st, wr_st_next;

  logic [3:0]  ar_id_q;
  logic [31:0] ar_addr_q;
  logic [2:0]  ar_size_q;
  logic [31:0] aw_addr_q;
  logic [2:0]  aw_size_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_pend, w_pend;

  logic inst_idle, data_idle, ar_free, wr_take, raw_hit;
  logic req_inst, req_data, gnt_inst, gnt_data;
  logic r_inst, r_data, b_done;

  // The fetch port never writes; its write-side inputs are intentionally dropped.
  logic unused_inst;
  assign unused_inst = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata};

  always_comb begin
    inst_idle = (inst_rd == RD_IDLE);
    data_idle = (data_rd == RD_IDLE) && (wr_st == WR_IDLE);
    ar_free   = (inst_rd != RD_AR) && (data_rd != RD_AR);
    wr_take   = resetn && data_sram_req && data_sram_wr && data_idle;
    // A write accepted this cycle counts as pending too, since AW and AR are unordered on AXI.
    raw_hit   = ((wr_st != WR_IDLE) || wr_take) &&
                (inst_sram_addr[31:2] == (wr_take ? data_sram_addr[31:2] : aw_addr_q[31:2]));
    req_inst  = resetn && inst_sram_req && inst_idle && ar_free && !raw_hit;
    req_data  = resetn && data_sram_req && !data_sram_wr && data_idle && ar_free;
    r_inst    = rvalid && (rid == ID_INST) && (inst_rd == RD_RESP);
    r_data    = rvalid && (rid == ID_DATA) && (data_rd == RD_RESP);
    b_done    = bvalid && (wr_st == WR_B);
  end

  axi_rd_arb u_rd_arb (
`ifdef ARB_RR_EN
    .clk        (clk),
    .resetn     (resetn),
`endif
    .req_inst   (req_inst),
    .req_data   (req_data),
    .grant_inst (gnt_inst),
    .grant_data (gnt_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_rd <= RD_IDLE;
      data_rd <= RD_IDLE;
      wr_st   <= WR_IDLE;
    end else begin
      inst_rd <= inst_rd_next;
      data_rd <= data_rd_next;
      wr_st   <= wr_st_next;
    end
  end

  always_comb begin
    inst_rd_next = inst_rd;
    data_rd_next = data_rd;
    wr_st_next   = wr_st;
    case (inst_rd)
      RD_IDLE: if (gnt_inst) inst_rd_next = RD_AR;
      RD_AR:   if (arready)  inst_rd_next = RD_RESP;
      RD_RESP: if (r_inst)   inst_rd_next = RD_IDLE;
      default: inst_rd_next = RD_IDLE;
    endcase
    case (data_rd)
      RD_IDLE: if (gnt_data) data_rd_next = RD_AR;
      RD_AR:   if (arready)  data_rd_next = RD_RESP;
      RD_RESP: if (r_data)   data_rd_next = RD_IDLE;
      default: data_rd_next = RD_IDLE;
    endcase
    case (wr_st)
      WR_IDLE: if (wr_take) wr_st_next = WR_AW_W;
      WR_AW_W: if ((!aw_pend || awready) && (!w_pend || wready)) wr_st_next = WR_B;
      WR_B:    if (bvalid) wr_st_next = WR_IDLE;
      default: wr_st_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_id_q   <= '0;
      ar_addr_q <= '0;
      ar_size_q <= '0;
      aw_addr_q <= '0;
      aw_size_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
    end else begin
      if (gnt_inst) begin
        ar_id_q   <= ID_INST;
        ar_addr_q <= inst_sram_addr;
        ar_size_q <= axi_size(inst_sram_size);
      end else if (gnt_data) begin
        ar_id_q   <= ID_DATA;
        ar_addr_q <= data_sram_addr;
        ar_size_q <= axi_size(data_sram_size);
      end
      if (wr_take) begin
        aw_addr_q <= data_sram_addr;
        aw_size_q <= axi_size(data_sram_size);
        w_data_q  <= data_sram_wdata;
        w_strb_q  <= data_sram_wstrb;
        aw_pend   <= 1'b1;
        w_pend    <= 1'b1;
      end else begin
        if (awready) aw_pend <= 1'b0;
        if (wready)  w_pend  <= 1'b0;
      end
    end
  end

  always_comb begin
    arvalid           = (inst_rd == RD_AR) || (data_rd == RD_AR);
    awvalid           = (wr_st == WR_AW_W) && aw_pend;
    wvalid            = (wr_st == WR_AW_W) && w_pend;
    inst_sram_addr_ok = gnt_inst;
    data_sram_addr_ok = gnt_data || wr_take;
    inst_sram_data_ok = r_inst;
    data_sram_data_ok = r_data || b_done;
  end

  assign inst_sram_rdata = rdata;
  assign data_sram_rdata = rdata;

  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arsize  = ar_size_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign rready  = 1'b1;

  assign awid    = ID_WRITE;
  assign awaddr  = aw_addr_q;
  assign awsize  = aw_size_q;
  assign awlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;

  assign wid     = ID_WRITE;
  assign wdata   = w_data_q;
  assign wstrb   = w_strb_q;
  assign wlast   = 1'b1;
  assign bready  = 1'b1;

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Bench for sram_axi_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_sram_axi_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        inst_sram_req, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0]  arid, arcache, rid, awid, awcache, wid, wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic        arvalid, arready, rvalid, rready, awvalid, awready;
  logic        wlast, wvalid, wready, bvalid, bready;

  sram_axi_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", tag, got, exp, $time);
  endtask

  // Transaction-level model: who is outstanding, what the AR slot holds, which write phases finished.
  bit          m_inst_out, m_data_out, m_ar_busy, m_wr_pend, m_aw_done, m_w_done, m_last_data;
  bit          m_r_pend [2];
  logic [3:0]  m_ar_id;
  logic [31:0] m_ar_addr, m_wr_addr, m_wr_data;
  logic [2:0]  m_ar_size, m_wr_size;
  logic [3:0]  m_wr_strb;

  // Stimulus knobs: requester requests hold until accepted; slave behaviour per cycle.
  bit          k_inst_req, k_data_req, k_data_wr, k_arready, k_awready, k_wready, k_bgo;
  logic [31:0] k_inst_addr, k_data_addr, k_wdata, k_rdata;
  logic [1:0]  k_inst_size, k_data_size;
  logic [3:0]  k_wstrb;
  int          k_rsel;

  task automatic quiet();
    k_inst_req = 0; k_data_req = 0; k_data_wr = 0;
    k_arready = 0; k_awready = 0; k_wready = 0; k_bgo = 0; k_rsel = -1; k_rdata = '0;
  endtask

  task automatic model_reset();
    m_inst_out = 0; m_data_out = 0; m_ar_busy = 0; m_wr_pend = 0;
    m_aw_done = 0; m_w_done = 0; m_last_data = 0;
    m_r_pend[0] = 0; m_r_pend[1] = 0;
    m_ar_id = '0; m_ar_addr = '0; m_ar_size = '0;
    m_wr_addr = '0; m_wr_data = '0; m_wr_size = '0; m_wr_strb = '0;
  endtask

  task automatic cycle();
    bit e_dwr, e_drd, e_inst, raw, g_data, g_inst;
    @(negedge clk);
    resetn          = 1'b1;
    inst_sram_req   = k_inst_req;
    inst_sram_addr  = k_inst_addr;
    inst_sram_size  = k_inst_size;
    inst_sram_wr    = 1'($urandom_range(0, 1));
    inst_sram_wstrb = 4'($urandom);
    inst_sram_wdata = $urandom;
    data_sram_req   = k_data_req;
    data_sram_wr    = k_data_wr;
    data_sram_addr  = k_data_addr;
    data_sram_size  = k_data_size;
    data_sram_wdata = k_wdata;
    data_sram_wstrb = k_wstrb;
    arready = k_arready;
    awready = k_awready;
    wready  = k_wready;
    bvalid  = k_bgo && m_wr_pend && m_aw_done && m_w_done;
    rvalid  = 1'b0;
    rid     = 4'($urandom);
    rdata   = $urandom;
    if (k_rsel inside {0, 1} && m_r_pend[k_rsel]) begin
      rvalid = 1'b1;
      rid    = 4'(k_rsel);
      rdata  = k_rdata;
    end
    #1;
    e_dwr = k_data_req && k_data_wr && !m_data_out;
    e_drd = k_data_req && !k_data_wr && !m_data_out && !m_ar_busy;
    raw   = (m_wr_pend || e_dwr) &&
            (k_inst_addr[31:2] == (m_wr_pend ? m_wr_addr[31:2] : k_data_addr[31:2]));
    e_inst = k_inst_req && !m_inst_out && !m_ar_busy && !raw;
`ifdef ARB_RR_EN
    g_data = e_drd && !(e_inst && m_last_data);
`else
    g_data = e_drd;
`endif
    g_inst = e_inst && !g_data;

    check_eq("inst_addr_ok", inst_sram_addr_ok, g_inst);
    check_eq("data_addr_ok", data_sram_addr_ok, g_data || e_dwr);
    check_eq("inst_data_ok", inst_sram_data_ok, rvalid && rid == 4'd0);
    check_eq("data_data_ok", data_sram_data_ok, (rvalid && rid == 4'd1) || bvalid);
    if (rvalid && rid == 4'd0) check_eq("inst_rdata", inst_sram_rdata, k_rdata);
    if (rvalid && rid == 4'd1) check_eq("data_rdata", data_sram_rdata, k_rdata);
    check_eq("arvalid", arvalid, m_ar_busy);
    if (m_ar_busy) begin
      check_eq("arid", arid, m_ar_id);
      check_eq("araddr", araddr, m_ar_addr);
      check_eq("arsize", arsize, m_ar_size);
    end
    check_eq("awvalid", awvalid, m_wr_pend && !m_aw_done);
    check_eq("wvalid", wvalid, m_wr_pend && !m_w_done);
    if (m_wr_pend && !m_aw_done) begin
      check_eq("awaddr", awaddr, m_wr_addr);
      check_eq("awsize", awsize, m_wr_size);
    end
    if (m_wr_pend && !m_w_done) begin
      check_eq("wdata", wdata, m_wr_data);
      check_eq("wstrb", wstrb, m_wr_strb);
    end

    if (m_ar_busy && k_arready) begin
      m_r_pend[m_ar_id[0]] = 1;
      m_ar_busy = 0;
    end
    if (m_wr_pend && k_awready) m_aw_done = 1;
    if (m_wr_pend && k_wready) m_w_done = 1;
    if (rvalid) begin
      m_r_pend[rid[0]] = 0;
      if (rid == 4'd0) m_inst_out = 0;
      else m_data_out = 0;
    end
    if (bvalid) begin
      m_wr_pend = 0;
      m_data_out = 0;
    end
    if (e_dwr) begin
      m_data_out = 1; m_wr_pend = 1; m_aw_done = 0; m_w_done = 0;
      m_wr_addr = k_data_addr; m_wr_size = {1'b0, k_data_size};
      m_wr_data = k_wdata; m_wr_strb = k_wstrb;
      k_data_req = 0;
    end
    if (g_data) begin
      m_data_out = 1; m_ar_busy = 1; m_last_data = 1;
      m_ar_id = 4'd1; m_ar_addr = k_data_addr; m_ar_size = {1'b0, k_data_size};
      k_data_req = 0;
    end
    if (g_inst) begin
      m_inst_out = 1; m_ar_busy = 1; m_last_data = 0;
      m_ar_id = 4'd0; m_ar_addr = k_inst_addr; m_ar_size = {1'b0, k_inst_size};
      k_inst_req = 0;
    end
  endtask

  task automatic run(input int unsigned n);
    repeat (n) cycle();
  endtask

  // Reset asserted mid-cycle with a request presented; outputs must drop at once.
  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    inst_sram_req = 1'b1; data_sram_req = 1'b1; data_sram_wr = 1'b0;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    #1;
    check_eq("rst_arvalid", arvalid, 0);
    check_eq("rst_awvalid", awvalid, 0);
    check_eq("rst_wvalid", wvalid, 0);
    check_eq("rst_inst_addr_ok", inst_sram_addr_ok, 0);
    check_eq("rst_data_addr_ok", data_sram_addr_ok, 0);
    check_eq("rst_araddr", araddr, 0);
    model_reset();
    quiet();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_constants();
    check_eq("arlen", arlen, 0);
    check_eq("arburst", arburst, 1);
    check_eq("arlock", arlock, 0);
    check_eq("arcache", arcache, 0);
    check_eq("arprot", arprot, 0);
    check_eq("awid", awid, 1);
    check_eq("awlen", awlen, 0);
    check_eq("awburst", awburst, 1);
    check_eq("awlock", awlock, 0);
    check_eq("awcache", awcache, 0);
    check_eq("awprot", awprot, 0);
    check_eq("wid", wid, 1);
    check_eq("wlast", wlast, 1);
    check_eq("rready", rready, 1);
    check_eq("bready", bready, 1);
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h1C00_0100 + 32'($urandom_range(0, 15));
  endfunction

  task automatic set_write(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
    k_data_req = 1; k_data_wr = 1; k_data_addr = addr;
    k_data_size = 2'd2; k_wstrb = strb; k_wdata = data;
  endtask

  initial begin
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = '0; inst_sram_wstrb = '0;
    inst_sram_addr = '0; inst_sram_wdata = '0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = '0; data_sram_wstrb = '0;
    data_sram_addr = '0; data_sram_wdata = '0;
    k_inst_addr = '0; k_data_addr = '0; k_wdata = '0; k_wstrb = '0;
    k_inst_size = '0; k_data_size = '0;
    do_reset();
    check_constants();

    // Single inst read, arready two cycles late, response forwarded in the same cycle.
    k_inst_req = 1; k_inst_addr = 32'h1C00_0000; k_inst_size = 2'd2;
    run(3);
    k_arready = 1; run(1); k_arready = 0;
    k_rsel = 0; k_rdata = 32'h0280_0421; run(1); k_rsel = -1;
    run(1);

    // Simultaneous reads, twice, to exercise the tie rule.
    for (int unsigned i = 0; i < 2; i++) begin
      k_inst_req = 1; k_inst_addr = 32'h1C00_0200; k_inst_size = 2'd2;
      k_data_req = 1; k_data_wr = 0; k_data_addr = 32'h1C00_0300; k_data_size = 2'd1;
      k_arready = 1; run(4);
      k_rsel = 1; k_rdata = 32'hDA7A_0000 + 32'(i); run(1);
      k_rsel = 0; k_rdata = 32'h1257_0000 + 32'(i); run(1);
      quiet();
    end

    // Write with AW accepted before W.
    set_write(32'h1C00_0100, 4'b0011, 32'hA5A5_1234); k_data_size = 2'd1;
    run(1);
    k_awready = 1; run(1); k_awready = 0;
    run(2);
    k_wready = 1; run(1); k_wready = 0;
    run(1);
    k_bgo = 1; run(1); quiet(); run(1);

    // Read-after-write hazard: same word blocks, a different word does not.
    set_write(32'h1C00_0104, 4'b1111, 32'h1111_2222);
    k_awready = 1; k_wready = 1; run(1);
    k_inst_req = 1; k_inst_addr = 32'h1C00_0106; k_inst_size = 2'd1;
    run(4);
    k_bgo = 1; run(1); k_bgo = 0;
    k_arready = 1; run(2);
    k_rsel = 0; k_rdata = 32'h3333_4444; run(1); quiet();
    set_write(32'h1C00_0104, 4'b1111, 32'h5555_6666);
    run(1);
    k_inst_req = 1; k_inst_addr = 32'h1C00_0108; k_inst_size = 2'd2;
    run(1);
    k_awready = 1; k_wready = 1; k_arready = 1; run(2);
    k_bgo = 1; k_rsel = 0; k_rdata = 32'h7777_8888; run(2); quiet();

    // Out-of-order completion: data (rid 1) returns before inst (rid 0).
    k_inst_req = 1; k_inst_addr = 32'h1C00_0400; k_inst_size = 2'd2;
    k_arready = 1; run(1);
    k_data_req = 1; k_data_wr = 0; k_data_addr = 32'h1C00_0500; k_data_size = 2'd2;
    run(3);
    k_rsel = 1; k_rdata = 32'hD0D0_0001; run(1);
    k_rsel = 0; k_rdata = 32'hC0C0_0002; run(1); quiet();

    // Reset while arvalid is held, then a clean read accepted on the first edge.
    k_inst_req = 1; k_inst_addr = 32'h1C00_0600; k_inst_size = 2'd2;
    run(2);
    do_reset();
    k_inst_req = 1; k_inst_addr = 32'h1C00_0700; k_inst_size = 2'd2;
    k_arready = 1; run(2);
    k_rsel = 0; k_rdata = 32'h600D_0001; run(1); quiet(); run(1);

    // Random traffic with a randomly stalling slave.
    for (int unsigned c = 0; c < 4000; c++) begin
      if (!k_inst_req && $urandom_range(0, 2) == 0) begin
        k_inst_req = 1; k_inst_addr = rand_addr(); k_inst_size = 2'($urandom);
      end
      if (!k_data_req && $urandom_range(0, 2) == 0) begin
        k_data_req = 1; k_data_wr = 1'($urandom); k_data_addr = rand_addr();
        k_data_size = 2'($urandom); k_wdata = $urandom; k_wstrb = 4'($urandom);
      end
      k_arready = ($urandom_range(0, 2) != 0);
      k_awready = 1'($urandom);
      k_wready  = 1'($urandom);
      k_bgo     = 1'($urandom);
      k_rsel    = $urandom_range(0, 3);
      if (k_rsel > 1) k_rsel = -1;
      k_rdata   = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_axi_arbiter.md
SRAM_AXI_ARBITER -- requirements
Module: sram_axi_arbiter

Interface
REQ-001 Clock and reset SHALL be: clk input 1 system clock; resetn input 1 asynchronous active-low reset.
REQ-002 inst_sram_req/wr/size[1:0]/wstrb[3:0]/addr[31:0]/wdata[31:0] SHALL be inputs; inst_sram_addr_ok, inst_sram_data_ok and inst_sram_rdata[31:0] SHALL be outputs, all SRAM-like, from the fetch stage.
REQ-003 data_sram_* SHALL use the same port set and directions as inst_sram_*, from the memory stage.
REQ-004 AXI read ports SHALL be: arid[3:0], araddr[31:0], arsize[2:0], arvalid out; arready in; rid[3:0], rdata[31:0], rvalid in; rready out.
REQ-005 AXI write ports SHALL be: awaddr[31:0], awsize[2:0], awvalid, wdata[31:0], wstrb[3:0], wvalid out; awready, wready in; bvalid in; bready out.
REQ-006 Constants SHALL be: arlen/awlen=0, arburst/awburst=2'b01, lock/cache/prot=0, awid/wid=1, wlast=1.

Function
REQ-007 IDs SHALL be: inst read arid=0, data read arid=1.
REQ-008 Each requester SHALL have at most one outstanding transaction (read or write).
REQ-009 Read FSM SHALL have states IDLE, AR (arvalid held, address stable until arready) and RESP (awaiting rvalid).
REQ-010 Write FSM SHALL have states IDLE, AW_W (awvalid/wvalid each drop after own handshake) and B (awaiting bvalid).
REQ-011 addr_ok SHALL pulse combinationally in the cycle a request is latched: requester idle, target FSM idle, grant won.
REQ-012 Grant for the shared AR slot: data over inst by default.
REQ-013 Reads to the two IDs SHALL overlap; the AR slot accepts the next read once the previous arready has occurred.
REQ-014 rready and bready SHALL be constant 1.
REQ-015 On rvalid, rid SHALL select the destination; data_ok SHALL be asserted in the same cycle with rdata passed through combinationally.
REQ-016 Write data_ok SHALL pulse on bvalid.
REQ-017 RAW guard: inst read SHALL NOT get addr_ok while a data write is pending with equal addr[31:2].
REQ-018 araddr/awaddr SHALL be the latched requester address; arsize/awsize SHALL be {1'b0,size}.
REQ-019 Simultaneous rvalid and bvalid SHALL both be handled in the same cycle.
REQ-020 A data request with wr=1 SHALL be routed to the write FSM only; inst wr SHALL be ignored (treated as read).

Reset
REQ-021 Reset SHALL put both FSMs in IDLE, clear outstanding flags, drive arvalid/awvalid/wvalid/addr_ok/data_ok low, and clear latched address/data to 0, regardless of in-flight AXI traffic.
REQ-022 After reset release, the first request SHALL be acceptable in the first clk edge.

Configuration
REQ-023 With ARB_RR_EN defined, AR grant SHALL be round-robin, with the last winner losing the next tie; without it, data SHALL have fixed priority.

Structure
REQ-024 A shared package/header SHALL hold the AXI burst/size constants, ID values and FSM state encodings.
REQ-025 One sub-module, axi_rd_arb (grant plus round-robin pointer), is natural; write path stays inline.

Verification
REQ-026 Inst read 0x1C000000, arready after 2 cycles, rvalid rid=0 rdata=0x02800421 -> inst_data_ok 1 cycle, inst_rdata=0x02800421.
REQ-027 Inst and data read same cycle, fixed priority -> arid=1 first, then arid=0; with ARB_RR_EN repeated ties alternate.
REQ-028 Data write 0x1C000100, wstrb=4'b0011, awready before wready -> awvalid drops first, wvalid held, data_ok on bvalid.
REQ-029 Pending write to 0x1C000104, inst read 0x1C000106 -> no inst addr_ok until bvalid; read to 0x1C000108 is not blocked.
REQ-030 Reads out of order, rid=1 returns before rid=0 -> each data_ok goes to the correct requester.
REQ-031 resetn low while arvalid is high -> arvalid low immediately; clean read after release.
